alu_issue_ctrl: RTL

//  Issue sequencer between decode and the ALU. Buffers decoded micro-ops in a small FIFO,

---
 rtl/alu_issue_ctrl_pkg.sv | 38 +++
 rtl/alu_issue_ctrl_if.sv | 40 ++++
 rtl/alu_issue_ctrl_uop_fifo.sv | 60 ++++++
 rtl/alu_issue_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_pkg : shared types, opcode constants and decode helpers         |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
package alu_issue_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        MUL_WAIT = 2'd2,
        BR_WAIT  = 2'd3
    } issue_state_t;

    typedef struct packed {
        logic [9:0]  opcode;
        logic [63:0] oprd1;
        logic [63:0] oprd2;
        logic [63:0] oprd3;
        logic [63:0] next_rip;
    } uop_t;

    localparam logic [9:0] OP_IMUL      = 10'h0F7;
    localparam logic [9:0] OP_JMP_REL32 = 10'h0E9;
    localparam logic [9:0] OP_JMP_REL8  = 10'h0EB;

    function automatic logic is_mul(input logic [9:0] op);
        return op == OP_IMUL;
    endfunction

    // Jcc short (0x070-0x07F), JMP rel32/rel8, Jcc near on the 0x1xx map (0x180-0x18F).
    function automatic logic is_branch(input logic [9:0] op);
        return (op[9:4] == 6'h07) || (op == OP_JMP_REL32) ||
               (op == OP_JMP_REL8) || (op[9:4] == 6'h18);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_ctrl_if : decode / ALU / memory-stage signals of the sequencer |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
interface alu_issue_ctrl_if;
    logic        dec_valid;
    logic        dec_ready;
    logic [9:0]  dec_opcode;
    logic [63:0] dec_oprd1;
    logic [63:0] dec_oprd2;
    logic [63:0] dec_oprd3;
    logic [63:0] dec_next_rip;
    logic        alu_enable;
    logic [9:0]  alu_opcode;
    logic [63:0] alu_oprd1;
    logic [63:0] alu_oprd2;
    logic [63:0] alu_oprd3;
    logic [63:0] alu_next_rip;
    logic        mem_blocked;
    logic        alu_branch;
    logic        busy;

    // Surrounding pipeline (decode, ALU, memory stage)
    modport master (
        output dec_valid, dec_opcode, dec_oprd1, dec_oprd2, dec_oprd3, dec_next_rip,
        output mem_blocked, alu_branch,
        input  dec_ready, alu_enable, alu_opcode, alu_oprd1, alu_oprd2, alu_oprd3,
        input  alu_next_rip, busy
    );

    // Issue controller
    modport slave (
        input  dec_valid, dec_opcode, dec_oprd1, dec_oprd2, dec_oprd3, dec_next_rip,
        input  mem_blocked, alu_branch,
        output dec_ready, alu_enable, alu_opcode, alu_oprd1, alu_oprd2, alu_oprd3,
        output alu_next_rip, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl_uop_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uop_fifo : DEPTH-entry micro-op queue with push/pop/clear and occupancy  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uop_fifo
    import alu_issue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire uop_t             wdata_i,
    input  wire logic             pop_i,
    input  wire logic             clear_i,
    output uop_t                  rdata_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    uop_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_i && !pop_i)      count_q <= count_q + CNT_W'(1);
            else if (pop_i && !push_i) count_q <= count_q - CNT_W'(1);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_ctrl : queues decoded micro-ops and issues one per cycle to the |
// | ALU, holding for IMUL latency, branch shadows and memory-stage stalls.    |
// | Optional: ALU_ISSUE_PERF_EN adds saturating issue/stall/flush counters.   |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_issue_ctrl_if.slave  bus
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall,
    output logic [31:0]      perf_flush
`endif
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [MCNT_W-1:0] MUL_INIT = MCNT_W'(MUL_LAT - 1);

    issue_state_t      state_q;
    logic [MCNT_W-1:0] mul_cnt_q;
    logic              alu_enable_q;
    uop_t              alu_uop_q;

    uop_t              fifo_head;
    uop_t              dec_uop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              flush;
    logic              mul_hold;

    assign dec_uop = '{opcode:   bus.dec_opcode,
                       oprd1:    bus.dec_oprd1,
                       oprd2:    bus.dec_oprd2,
                       oprd3:    bus.dec_oprd3,
                       next_rip: bus.dec_next_rip};

    // A redirect is only honoured in the shadow cycle right after a branch issues.
    assign flush    = (state_q == BR_WAIT) && bus.alu_branch && !bus.mem_blocked;
    assign push     = bus.dec_valid && bus.dec_ready;
    assign mul_hold = is_mul(alu_uop_q.opcode) && (MUL_LAT > 1);

    always_comb begin
        pop = 1'b0;
        if (!bus.mem_blocked && !fifo_empty) begin
            unique case (state_q)
                IDLE:     pop = 1'b1;
                ISSUE:    pop = !mul_hold && !is_branch(alu_uop_q.opcode);
                MUL_WAIT: pop = (mul_cnt_q == MCNT_W'(1));
                BR_WAIT:  pop = 1'b0;
                default:  pop = 1'b0;
            endcase
        end
    end

    uop_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (dec_uop),
        .pop_i   (pop),
        .clear_i (flush),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Whole state machine freezes under mem_blocked, so outputs simply hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mul_cnt_q    <= '0;
            alu_enable_q <= 1'b0;
            alu_uop_q    <= '0;
        end else if (!bus.mem_blocked) begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        alu_uop_q    <= fifo_head;
                        alu_enable_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mul_hold) begin
                        mul_cnt_q <= MUL_INIT;
                        state_q   <= MUL_WAIT;
                    end else if (is_branch(alu_uop_q.opcode)) begin
                        alu_enable_q <= 1'b0;
                        state_q      <= BR_WAIT;
                    end else if (pop) begin
                        alu_uop_q <= fifo_head;
                    end else begin
                        alu_enable_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                MUL_WAIT: begin
                    if (mul_cnt_q == MCNT_W'(1)) begin
                        if (pop) begin
                            alu_uop_q <= fifo_head;
                            state_q   <= ISSUE;
                        end else begin
                            alu_enable_q <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end else begin
                        mul_cnt_q <= mul_cnt_q - MCNT_W'(1);
                    end
                end
                BR_WAIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    alu_enable_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.dec_ready    = !fifo_full && !flush;
    assign bus.alu_enable   = alu_enable_q;
    assign bus.alu_opcode   = alu_uop_q.opcode;
    assign bus.alu_oprd1    = alu_uop_q.oprd1;
    assign bus.alu_oprd2    = alu_uop_q.oprd2;
    assign bus.alu_oprd3    = alu_uop_q.oprd3;
    assign bus.alu_next_rip = alu_uop_q.next_rip;
    assign bus.busy         = (fifo_count != '0) || (state_q != IDLE);

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (pop && (perf_issued_q != '1))
                perf_issued_q <= perf_issued_q + 32'd1;
            if (!fifo_empty && !pop && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
            if (flush && (perf_flush_q != '1))
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
    assign perf_flush  = perf_flush_q;
`endif

endmodule
`default_nettype wire
